// File: rtl/line_way_select_merge_pkg.sv
// Shared types and helpers for the cache line way-select / write-merge stage.
package line_way_select_merge_pkg;

   localparam int LINE_BITS_DEF = 128;
   localparam int OFF_BITS_DEF  = $clog2(LINE_BITS_DEF / 8);

   typedef logic [OFF_BITS_DEF-1:0] lc3b_c_offset;

   typedef enum logic {
      ACC_WORD = 1'b0,
      ACC_BYTE = 1'b1
   } acc_mode_e;

   // A single way still needs a 1-bit index port.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/line_way_select_merge_if.sv
// Request/response bundle between the way datapath, this stage and the CPU/writeback side.
interface line_way_select_merge_if
   import line_way_select_merge_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int LINE_BITS = LINE_BITS_DEF,
   parameter int CNT_BITS  = 16
);
   localparam int OFF_BITS = $clog2(LINE_BITS / 8);
   localparam int WAY_BITS = way_bits(WAYS);

   logic                              in_valid;
   logic                              in_ready;
   logic [WAYS-1:0]                   way_hit;
   logic [WAYS-1:0][LINE_BITS-1:0]    way_data;
   logic [OFF_BITS-1:0]               offset;
   logic                              byte_mode;
   logic                              wr_en;
   logic [15:0]                       wr_data;

   logic                              out_valid;
   logic                              out_ready;
   logic [15:0]                       out_word;
   logic [LINE_BITS-1:0]              out_line;
   logic [WAY_BITS-1:0]               out_way;
   logic                              out_hit;
   logic                              out_multihit;
   logic                              out_misalign;

   logic                              cnt_clear;
   logic [CNT_BITS-1:0]               hit_cnt;
   logic [CNT_BITS-1:0]               miss_cnt;

   modport master (
      output in_valid, way_hit, way_data, offset, byte_mode, wr_en, wr_data,
      output out_ready, cnt_clear,
      input  in_ready, out_valid, out_word, out_line, out_way, out_hit,
      input  out_multihit, out_misalign, hit_cnt, miss_cnt
   );

   modport slave (
      input  in_valid, way_hit, way_data, offset, byte_mode, wr_en, wr_data,
      input  out_ready, cnt_clear,
      output in_ready, out_valid, out_word, out_line, out_way, out_hit,
      output out_multihit, out_misalign, hit_cnt, miss_cnt
   );

endinterface

// File: rtl/line_way_select_merge_line_byte_merge.sv
// Combinational word/byte extract and write-merge on one cache line.
// The extracted word always comes from the line before the merge.
module line_byte_merge
   import line_way_select_merge_pkg::*;
#(
   parameter int LINE_BITS = LINE_BITS_DEF
) (
   input  logic [LINE_BITS-1:0]              line_i,
   input  logic [$clog2(LINE_BITS/8)-1:0]    offset_i,
   input  acc_mode_e                         mode_i,
   input  logic                              wr_en_i,
   input  logic [15:0]                       wr_data_i,
   output logic [15:0]                       out_word_o,
   output logic [LINE_BITS-1:0]              merged_line_o,
   output logic                              misalign_o
);
   localparam int OFF_BITS = $clog2(LINE_BITS / 8);

   logic [OFF_BITS-1:0] word_base;
   logic [15:0]         rd_word;
   logic [7:0]          rd_byte;

   always_comb begin
      word_base    = offset_i;
      word_base[0] = 1'b0;
      rd_word      = line_i[{word_base, 3'b000} +: 16];
      rd_byte      = line_i[{offset_i, 3'b000} +: 8];

      merged_line_o = line_i;
      if (wr_en_i) begin
         if (mode_i == ACC_BYTE) begin
            merged_line_o[{offset_i, 3'b000} +: 8] = wr_data_i[7:0];
         end else begin
            merged_line_o[{word_base, 3'b000} +: 16] = wr_data_i;
         end
      end

      out_word_o = (mode_i == ACC_BYTE) ? {8'h00, rd_byte} : rd_word;
      misalign_o = (mode_i == ACC_WORD) && offset_i[0];
   end

endmodule

// File: rtl/line_way_select_merge.sv
// Way priority select, single registered valid/ready stage and saturating hit/miss counters
// between the cache way datapath and the CPU/writeback side.
module line_way_select_merge
   import line_way_select_merge_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int LINE_BITS = LINE_BITS_DEF,
   parameter int CNT_BITS  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   line_way_select_merge_if.slave    bus
);
   localparam int WAY_BITS = way_bits(WAYS);

   logic [WAY_BITS-1:0]   sel_way;
   logic [LINE_BITS-1:0]  sel_line;
   logic                  any_hit;
   logic                  multi_hit;
   logic                  accept;

   logic [15:0]           mrg_word;
   logic [LINE_BITS-1:0]  mrg_line;
   logic                  mrg_misalign;

   logic                  valid_q,    valid_d;
   logic [15:0]           word_q,     word_d;
   logic [LINE_BITS-1:0]  line_q,     line_d;
   logic [WAY_BITS-1:0]   way_q,      way_d;
   logic                  hit_q,      hit_d;
   logic                  multihit_q, multihit_d;
   logic                  misalign_q, misalign_d;
   logic [CNT_BITS-1:0]   hit_cnt_q,  hit_cnt_d;
   logic [CNT_BITS-1:0]   miss_cnt_q, miss_cnt_d;

   // Scan from the top down so the lowest set index wins; no hit leaves way 0.
   always_comb begin
      sel_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (bus.way_hit[w]) sel_way = WAY_BITS'(w);
      end
   end

   assign sel_line  = bus.way_data[sel_way];
   assign any_hit   = |bus.way_hit;
   assign multi_hit = |(bus.way_hit & (bus.way_hit - WAYS'(1)));

   line_byte_merge #(
      .LINE_BITS (LINE_BITS)
   ) u_merge (
      .line_i        (sel_line),
      .offset_i      (bus.offset),
      .mode_i        (acc_mode_e'(bus.byte_mode)),
      .wr_en_i       (bus.wr_en),
      .wr_data_i     (bus.wr_data),
      .out_word_o    (mrg_word),
      .merged_line_o (mrg_line),
      .misalign_o    (mrg_misalign)
   );

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      valid_d    = valid_q;
      word_d     = word_q;
      line_d     = line_q;
      way_d      = way_q;
      hit_d      = hit_q;
      multihit_d = multihit_q;
      misalign_d = misalign_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;

      if (accept) begin
         valid_d    = 1'b1;
         word_d     = mrg_word;
         line_d     = mrg_line;
         way_d      = sel_way;
         hit_d      = any_hit;
         multihit_d = multi_hit;
         misalign_d = mrg_misalign;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end

      // Clear beats a same-cycle increment.
      if (bus.cnt_clear) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (accept) begin
         if (any_hit) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
         end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         word_q     <= '0;
         line_q     <= '0;
         way_q      <= '0;
         hit_q      <= 1'b0;
         multihit_q <= 1'b0;
         misalign_q <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         word_q     <= word_d;
         line_q     <= line_d;
         way_q      <= way_d;
         hit_q      <= hit_d;
         multihit_q <= multihit_d;
         misalign_q <= misalign_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_word     = word_q;
   assign bus.out_line     = line_q;
   assign bus.out_way      = way_q;
   assign bus.out_hit      = hit_q;
   assign bus.out_multihit = multihit_q;
   assign bus.out_misalign = misalign_q;
   assign bus.hit_cnt      = hit_cnt_q;
   assign bus.miss_cnt     = miss_cnt_q;

endmodule
